// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: state encoding, default sizing and nbits clamp shared by the ADC sequencer
package adc_seq_pkg;
    localparam int MAX_BITS_DEF = 16;
    typedef enum logic [2:0] {IDLE, INIT, SAMP, COMP, UPDATE, DONE} seq_state_t;
    function automatic logic [4:0] clamp_nbits(input logic [4:0] n, input int max_bits);
        return (n == 5'd0) ? 5'd1 : (int'(n) > max_bits) ? 5'(max_bits) : n;
    endfunction
endpackage

// File: rtl/seq_phase_counter.sv
// seq_phase_counter: loadable down-counter timing one sequencer phase; a length of 0 behaves as 1
module seq_phase_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    output logic             zero
);
    logic [LEN_W-1:0] cnt;
    // load len-1 on phase entry, then count down and park at zero
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (load) cnt <= (len == '0) ? '0 : len - 1'b1;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    assign zero = (cnt == '0);
endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer: SAR ADC phase timing master and MSB-first result capture; ADC_SEQ_CONTINUOUS_EN adds cont_mode for back-to-back conversions
module adc_sequencer
    import adc_seq_pkg::*;
#(
    parameter int MAX_BITS = MAX_BITS_DEF,
    parameter int LEN_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    cfg_samp_len,
    input  logic [LEN_W-1:0]    cfg_comp_len,
    input  logic [LEN_W-1:0]    cfg_update_len,
    input  logic [4:0]          cfg_nbits,
    input  logic                comp_out,
`ifdef ADC_SEQ_CONTINUOUS_EN
    input  logic                cont_mode,
`endif
    output logic                seq_init,
    output logic                seq_samp,
    output logic                seq_comp,
    output logic                seq_update,
    output logic                busy,
    output logic [MAX_BITS-1:0] result,
    output logic                result_valid
);
    seq_state_t          state, nxt;
    logic [LEN_W-1:0]    samp_len, comp_len, update_len, len;
    logic [4:0]          nbits, bit_cnt;
    logic [MAX_BITS-1:0] work;
    logic                zero, load, accept, cont;

`ifdef ADC_SEQ_CONTINUOUS_EN
    assign cont = cont_mode;
`else
    assign cont = 1'b0;
`endif

    assign accept = (state == IDLE && start) || (state == DONE && cont);
    assign load   = (nxt != state) && (nxt == SAMP || nxt == COMP || nxt == UPDATE);
    assign len    = (nxt == SAMP) ? samp_len : (nxt == COMP) ? comp_len : update_len;

    seq_phase_counter #(.LEN_W(LEN_W)) u_phase (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .len  (len),
        .zero (zero)
    );

    // phase sequencing: each timed phase leaves when its counter reaches zero
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? INIT : IDLE;
            INIT:    nxt = SAMP;
            SAMP:    nxt = zero ? COMP : SAMP;
            COMP:    nxt = zero ? UPDATE : COMP;
            UPDATE:  nxt = zero ? ((bit_cnt == nbits - 5'd1) ? DONE : COMP) : UPDATE;
            DONE:    nxt = cont ? INIT : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state, outputs registered from the next state, config latch and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            seq_init     <= 1'b0;
            seq_samp     <= 1'b0;
            seq_comp     <= 1'b0;
            seq_update   <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            samp_len     <= '0;
            comp_len     <= '0;
            update_len   <= '0;
            nbits        <= 5'd1;
            bit_cnt      <= '0;
            work         <= '0;
        end else begin
            state        <= nxt;
            seq_init     <= (nxt == INIT);
            seq_samp     <= (nxt == SAMP);
            seq_comp     <= (nxt == COMP);
            seq_update   <= (nxt == UPDATE);
            busy         <= (nxt != IDLE);
            result_valid <= (state == DONE);
            if (state == DONE) result <= work;
            if (accept) begin
                samp_len   <= cfg_samp_len;
                comp_len   <= cfg_comp_len;
                update_len <= cfg_update_len;
                nbits      <= clamp_nbits(cfg_nbits, MAX_BITS);
                bit_cnt    <= '0;
                work       <= '0;
            end
            if (state == COMP && zero) work <= {work[MAX_BITS-2:0], comp_out};
            if (state == UPDATE && zero) bit_cnt <= bit_cnt + 5'd1;
        end
    end
endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer: directed and randomized conversions checked against a phase-timeline model
module tb_adc_sequencer;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, comp_out = 1'b0;
    logic [7:0]  cfg_samp_len = '0, cfg_comp_len = '0, cfg_update_len = '0;
    logic [4:0]  cfg_nbits = '0;
    logic        seq_init, seq_samp, seq_comp, seq_update, busy, result_valid;
    logic [15:0] result;
`ifdef ADC_SEQ_CONTINUOUS_EN
    logic        cont_mode = 1'b0;
`endif
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    adc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_samp_len   (cfg_samp_len),
        .cfg_comp_len   (cfg_comp_len),
        .cfg_update_len (cfg_update_len),
        .cfg_nbits      (cfg_nbits),
        .comp_out       (comp_out),
`ifdef ADC_SEQ_CONTINUOUS_EN
        .cont_mode      (cont_mode),
`endif
        .seq_init       (seq_init),
        .seq_samp       (seq_samp),
        .seq_comp       (seq_comp),
        .seq_update     (seq_update),
        .busy           (busy),
        .result         (result),
        .result_valid   (result_valid)
    );

    localparam logic [4:0] V_IDLE = 5'b00000, V_INIT = 5'b10001, V_SAMP = 5'b01001,
                           V_COMP = 5'b00101, V_UPD = 5'b00011, V_DONE = 5'b00001;

    function automatic logic [4:0] obs();
        return {seq_init, seq_samp, seq_comp, seq_update, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got %h expected %h", tag, got, exp);
    endtask

    // Model: a conversion is INIT, S samp cycles, then per bit C comp + U update cycles, then DONE.
    // Bit b's decision is comp_out in the last COMP cycle of bit b; result = first en pattern bits.
    task automatic run_conv(input logic [7:0] s, input logic [7:0] c, input logic [7:0] u,
                            input logic [4:0] n, input logic [15:0] pat, input bit skip_start,
                            input bit cont_next, input bit perturb, input bit use_fixed,
                            input logic [15:0] fixed_exp);
        logic [4:0] tl[$];
        int es, ec, eu, en, b, comps;
        logic prev;
        logic [15:0] exp_res;
        es = (s == 0) ? 1 : int'(s);
        ec = (c == 0) ? 1 : int'(c);
        eu = (u == 0) ? 1 : int'(u);
        en = (n == 0) ? 1 : (n > 16) ? 16 : int'(n);
        tl.push_back(V_INIT);
        repeat (es) tl.push_back(V_SAMP);
        for (int k = 0; k < en; k++) begin
            repeat (ec) tl.push_back(V_COMP);
            repeat (eu) tl.push_back(V_UPD);
        end
        tl.push_back(V_DONE);
        exp_res = pat >> (16 - en);
`ifdef ADC_SEQ_CONTINUOUS_EN
        cont_mode = cont_next;
`endif
        if (!skip_start) begin
            cfg_samp_len = s; cfg_comp_len = c; cfg_update_len = u; cfg_nbits = n;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        b = 0; comps = 0; prev = 1'b0;
        for (int i = 0; i < tl.size(); i++) begin
            check($sformatf("phase[%0d]", i), 32'(obs()), 32'(tl[i]));
            check($sformatf("valid_low[%0d]", i), 32'(result_valid), 32'(skip_start && i == 0));
            if (seq_comp && !prev) comps++;
            prev = seq_comp;
            if (tl[i] == V_COMP && tl[i+1] != V_COMP) begin
                comp_out = pat[15-b];
                b++;
            end else comp_out = 1'($urandom);
            if (perturb) begin
                if (i == 2) begin start = 1'b1; cfg_samp_len = s + 8'd3; end
                if (i == 3) start = 1'b0;
                if (i == tl.size() - 1) start = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        cfg_samp_len = s;
        check("comp_pulses", 32'(comps), 32'(en));
        check("valid_pulse", 32'(result_valid), 32'd1);
        check("result", 32'(result), 32'(exp_res));
        if (use_fixed) check("result_const", 32'(result), 32'(fixed_exp));
        check("after_done", 32'(obs()), 32'(cont_next ? V_INIT : V_IDLE));
        if (!cont_next) begin
            @(posedge clk); #1;
            check("valid_one_cycle", 32'(result_valid), 32'd0);
            check("stay_idle", 32'(obs()), 32'(V_IDLE));
            check("result_hold", 32'(result), 32'(exp_res));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'(obs()), 32'(V_IDLE));
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", 32'(obs()), 32'(V_IDLE));

        // reset mid-COMP of bit 3 of 8 (S=2, C=3, U=1): that COMP spans cycles 15..17 after INIT
        cfg_samp_len = 8'd2; cfg_comp_len = 8'd3; cfg_update_len = 8'd1; cfg_nbits = 5'd8;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) begin
            comp_out = 1'($urandom);
            @(posedge clk); #1;
        end
        check("pre_rst_comp", 32'(obs()), 32'(V_COMP));
        rst = 1'b1;
        #1;
        check("async_rst_outputs", 32'(obs()), 32'(V_IDLE));
        check("async_rst_result", 32'(result), 32'd0);
        check("async_rst_valid", 32'(result_valid), 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(obs()), 32'(V_IDLE));
        check("no_partial_result", 32'(result_valid), 32'd0);

        run_conv(8'd4, 8'd2, 8'd1, 5'd8, 16'hB200, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00B2);
        run_conv(8'd0, 8'd0, 8'd0, 5'd0, 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        run_conv(8'd3, 8'd1, 8'd2, 5'd20, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        run_conv(8'd4, 8'd2, 8'd2, 5'd5, 16'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        repeat (6)
            run_conv(8'($urandom_range(0, 5)), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)),
                     5'($urandom_range(0, 20)), 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
`ifdef ADC_SEQ_CONTINUOUS_EN
        run_conv(8'd2, 8'd1, 8'd1, 5'd4, 16'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        run_conv(8'd2, 8'd1, 8'd1, 5'd4, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
